// File: rtl/v30mz_bus_pkg.sv
// Shared V30MZ bus definitions: status codes, responder states and lane helpers.
package v30mz_bus_pkg;

    typedef enum logic [3:0] {
        BUS_STATUS_IO_READ   = 4'b0101,
        BUS_STATUS_IO_WRITE  = 4'b0110,
        BUS_STATUS_MEM_READ  = 4'b1001,
        BUS_STATUS_MEM_WRITE = 4'b1010,
        BUS_STATUS_IDLE      = 4'b1111
    } bus_status_t;

    typedef enum logic [2:0] {
        RSP_IDLE,
        RSP_WAIT,
        RSP_IO_WAIT,
        RSP_DONE,
        RSP_TURN
    } rsp_state_t;

    // Returns {upper, lower}; an odd address without UBE selects no lane at all.
    function automatic logic [1:0] lane_decode(input logic a0, input logic ube);
        return {ube, ~a0};
    endfunction

    // Zeroes the byte lanes that are not part of the transfer, keeping bytes in place.
    function automatic logic [15:0] lane_mask(input logic [1:0] lanes, input logic [15:0] data);
        return {data[15:8] & {8{lanes[1]}}, data[7:0] & {8{lanes[0]}}};
    endfunction

endpackage

// File: rtl/bus_ram.sv
// Word-wide single-port RAM with per-byte write enables and a registered read port.
module bus_ram #(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [1:0]           we,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    logic [15:0] mem_q [2**ADDR_BITS];
    logic [15:0] rdata_q;

    // Read-first access; the read register holds its value until the next enabled access.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we[0]) mem_q[addr][7:0]  <= wdata[7:0];
            if (we[1]) mem_q[addr][15:8] <= wdata[15:8];
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/v30mz_bus_responder.sv
// Memory/IO responder for the V30MZ bus: serves memory from bus_ram, forwards IO
// cycles over a strobe/ack handshake and signals completion with active-low readyb.
module v30mz_bus_responder
    import v30mz_bus_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 16,
    parameter int WAIT_STATES   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] bus_address,
    input  logic [3:0]  bus_status,
    input  logic        bus_upper_byte_enable,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        readyb,
    output logic [15:0] io_address,
    output logic [1:0]  io_byte_enable,
    output logic        io_read,
    output logic        io_write,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    input  logic        io_ack
);

    localparam logic [3:0] WS = WAIT_STATES[3:0];

    rsp_state_t  state_q;
    logic        readyb_q;
    logic [1:0]  lanes_q;
    logic        src_io_q;
    logic [15:0] io_rdata_q;
    logic [15:0] io_address_q;
    logic [1:0]  io_be_q;
    logic [15:0] io_wdata_q;
    logic        io_read_q;
    logic        io_write_q;
    logic [3:0]  wcnt_q;

    logic        is_mem_d;
    logic        is_io_d;
    logic        is_write_d;
    logic [1:0]  lanes_d;
    logic        ram_en;
    logic [1:0]  ram_we;
    logic [15:0] ram_rdata;

    // Address bits above the RAM window only select a mirror.
    logic unused_addr;
    assign unused_addr = ^bus_address;

    // Classify the status code presented this cycle; unknown codes decode to nothing.
    always_comb begin
        is_mem_d   = 1'b0;
        is_io_d    = 1'b0;
        is_write_d = 1'b0;
        case (bus_status)
            BUS_STATUS_MEM_READ:  is_mem_d = 1'b1;
            BUS_STATUS_MEM_WRITE: begin is_mem_d = 1'b1; is_write_d = 1'b1; end
            BUS_STATUS_IO_READ:   is_io_d = 1'b1;
            BUS_STATUS_IO_WRITE:  begin is_io_d = 1'b1; is_write_d = 1'b1; end
            default: ;
        endcase
    end

    assign lanes_d = lane_decode(bus_address[0], bus_upper_byte_enable);

    // The RAM is touched only on the capture edge, so writes commit there and the
    // read register keeps the captured word for the rest of the cycle.
    assign ram_en = (state_q == RSP_IDLE) && is_mem_d && !reset;
    assign ram_we = {2{is_write_d}} & lanes_d;

    bus_ram #(
        .ADDR_BITS(MEM_ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .addr  (bus_address[MEM_ADDR_BITS:1]),
        .we    (ram_we),
        .wdata (bus_wdata),
        .rdata (ram_rdata)
    );

    // Responder FSM: capture, wait/handshake, one-cycle completion, one-cycle turnaround.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RSP_IDLE;
            readyb_q     <= 1'b1;
            lanes_q      <= 2'b00;
            src_io_q     <= 1'b0;
            io_rdata_q   <= 16'h0000;
            io_address_q <= 16'h0000;
            io_be_q      <= 2'b00;
            io_wdata_q   <= 16'h0000;
            io_read_q    <= 1'b0;
            io_write_q   <= 1'b0;
            wcnt_q       <= 4'd0;
        end else begin
            io_read_q  <= 1'b0;
            io_write_q <= 1'b0;
            case (state_q)
                RSP_IDLE: begin
                    readyb_q <= 1'b1;
                    if (is_mem_d) begin
                        lanes_q  <= lanes_d;
                        src_io_q <= 1'b0;
                        wcnt_q   <= WS;
                        if (WAIT_STATES == 0) begin
                            state_q  <= RSP_DONE;
                            readyb_q <= 1'b0;
                        end else begin
                            state_q <= RSP_WAIT;
                        end
                    end else if (is_io_d) begin
                        lanes_q      <= lanes_d;
                        src_io_q     <= 1'b1;
                        io_address_q <= bus_address[15:0];
                        io_be_q      <= lanes_d;
                        io_wdata_q   <= bus_wdata;
                        io_read_q    <= !is_write_d;
                        io_write_q   <= is_write_d;
                        state_q      <= RSP_IO_WAIT;
                    end
                end
                RSP_WAIT: begin
                    if (wcnt_q <= 4'd1) begin
                        state_q  <= RSP_DONE;
                        readyb_q <= 1'b0;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                RSP_IO_WAIT: begin
                    if (io_ack) begin
                        io_rdata_q <= lane_mask(lanes_q, io_rdata);
                        state_q    <= RSP_DONE;
                        readyb_q   <= 1'b0;
                    end
                end
                RSP_DONE: begin
                    readyb_q <= 1'b1;
                    state_q  <= RSP_TURN;
                end
                RSP_TURN: begin
                    state_q <= RSP_IDLE;
                end
                default: begin
                    state_q  <= RSP_IDLE;
                    readyb_q <= 1'b1;
                end
            endcase
        end
    end

    assign readyb         = readyb_q;
    assign bus_rdata      = src_io_q ? io_rdata_q : lane_mask(lanes_q, ram_rdata);
    assign io_address     = io_address_q;
    assign io_byte_enable = io_be_q;
    assign io_read        = io_read_q;
    assign io_write       = io_write_q;
    assign io_wdata       = io_wdata_q;

endmodule

// File: tb/tb_v30mz_bus_responder.sv
// Bench for v30mz_bus_responder: one instance with no wait states, one with three.
module tb_v30mz_bus_responder;

    localparam logic [3:0] ST_IDLE = 4'hf;
    localparam logic [3:0] ST_MRD  = 4'b1001;
    localparam logic [3:0] ST_MWR  = 4'b1010;
    localparam logic [3:0] ST_IORD = 4'b0101;
    localparam logic [3:0] ST_IOWR = 4'b0110;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] addr = 20'h0;
    logic        ube = 1'b0;
    logic [15:0] wdata = 16'h0;
    logic [3:0]  st0 = 4'hf;
    logic [3:0]  st3 = 4'hf;
    logic [15:0] io_rdata = 16'h0;
    logic        io_ack = 1'b0;

    logic [15:0] rd0, ioa0, iowd0, rd3, ioa3, iowd3;
    logic [1:0]  iobe0, iobe3;
    logic        rdyb0, ior0, iow0, rdyb3, ior3, iow3;

    int vectors = 0;
    int miscompares = 0;

    // Reference memory image, keyed by instance * 65536 + word index.
    logic [15:0] mem_m [int];
    logic [3:0]  codes [5] = '{ST_IDLE, ST_MRD, ST_MWR, ST_IORD, ST_IOWR};
    logic [19:0] pool [8];

    always #5 clk = ~clk;

    v30mz_bus_responder #(.MEM_ADDR_BITS(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus_address(addr), .bus_status(st0),
        .bus_upper_byte_enable(ube), .bus_wdata(wdata), .bus_rdata(rd0),
        .readyb(rdyb0), .io_address(ioa0), .io_byte_enable(iobe0),
        .io_read(ior0), .io_write(iow0), .io_wdata(iowd0),
        .io_rdata(io_rdata), .io_ack(io_ack)
    );

    v30mz_bus_responder #(.MEM_ADDR_BITS(16), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .bus_address(addr), .bus_status(st3),
        .bus_upper_byte_enable(ube), .bus_wdata(wdata), .bus_rdata(rd3),
        .readyb(rdyb3), .io_address(ioa3), .io_byte_enable(iobe3),
        .io_read(ior3), .io_write(iow3), .io_wdata(iowd3),
        .io_rdata(io_rdata), .io_ack(io_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_rdyb(input int d);
        return (d == 0) ? rdyb0 : rdyb3;
    endfunction

    function automatic logic [15:0] get_rd(input int d);
        return (d == 0) ? rd0 : rd3;
    endfunction

    task automatic set_st(input int d, input logic [3:0] v);
        if (d == 0) st0 = v; else st3 = v;
    endtask

    // One memory cycle on instance d; expected timing is readyb low exactly in cycle 1+ws.
    task automatic mem_op(input int d, input bit wr, input logic [19:0] a, input logic u,
                          input logic [15:0] w, input string tag);
        int ws = (d == 0) ? 0 : 3;
        int key = d * 65536 + int'(a[16:1]);
        logic [15:0] expv = 16'h0000;
        if (wr) begin
            if (!a[0]) mem_m[key][7:0] = w[7:0];
            if (u)     mem_m[key][15:8] = w[15:8];
        end else begin
            if (!a[0]) expv[7:0] = mem_m[key][7:0];
            if (u)     expv[15:8] = mem_m[key][15:8];
        end
        @(negedge clk);
        addr = a; ube = u; wdata = w; io_ack = 1'b0;
        set_st(d, wr ? ST_MWR : ST_MRD);
        @(posedge clk); #1;
        for (int k = 1; k <= ws + 2; k++) begin
            chk($sformatf("%s readyb k=%0d", tag, k), {31'd0, get_rdyb(d)},
                {31'd0, (k == ws + 1) ? 1'b0 : 1'b1});
            if (k == ws + 1 && !wr) chk({tag, " rdata"}, {16'd0, get_rd(d)}, {16'd0, expv});
            if (k == 1 && d == 0) chk({tag, " no io strobe"}, {30'd0, ior0, iow0}, 32'd0);
            @(negedge clk);
            addr = 20'($urandom); wdata = 16'($urandom); ube = 1'($urandom);
            io_ack = (k == ws + 2) ? 1'b0 : 1'($urandom);
            set_st(d, (k == ws + 2) ? ST_IDLE : codes[$urandom_range(4, 0)]);
            @(posedge clk); #1;
        end
    endtask

    // One IO cycle on instance 0 with io_ack raised during cycle dly (cycle 1 = strobe cycle).
    task automatic io_op(input bit wr, input logic [19:0] a, input logic u, input logic [15:0] w,
                         input int dly, input logic [15:0] rdv, input string tag);
        logic [1:0]  lanes = {u, ~a[0]};
        logic [15:0] expv = 16'h0000;
        if (!a[0]) expv[7:0] = rdv[7:0];
        if (u)     expv[15:8] = rdv[15:8];
        @(negedge clk);
        addr = a; ube = u; wdata = w; io_ack = 1'b0; st0 = wr ? ST_IOWR : ST_IORD;
        @(posedge clk); #1;
        for (int k = 1; k <= dly + 2; k++) begin
            chk($sformatf("%s readyb k=%0d", tag, k), {31'd0, rdyb0},
                {31'd0, (k == dly + 1) ? 1'b0 : 1'b1});
            chk($sformatf("%s strobes k=%0d", tag, k), {30'd0, ior0, iow0},
                {30'd0, (k == 1) && !wr, (k == 1) && wr});
            if (k == 1 || k == dly + 1) begin
                chk({tag, " io_address"}, {16'd0, ioa0}, {16'd0, a[15:0]});
                chk({tag, " io_byte_enable"}, {30'd0, iobe0}, {30'd0, lanes});
                if (wr) chk({tag, " io_wdata"}, {16'd0, iowd0}, {16'd0, w});
            end
            if (k == dly + 1 && !wr) chk({tag, " rdata"}, {16'd0, rd0}, {16'd0, expv});
            @(negedge clk);
            io_ack = (k == dly);
            io_rdata = (k == dly) ? rdv : 16'($urandom);
            addr = 20'($urandom); wdata = 16'($urandom);
            st0 = (k == dly + 2) ? ST_IDLE : codes[$urandom_range(4, 0)];
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1;
        chk("rst readyb", {30'd0, rdyb0, rdyb3}, 32'd3);
        chk("rst rdata", {rd0, rd3}, 32'd0);
        chk("rst strobes", {28'd0, ior0, iow0, ior3, iow3}, 32'd0);
        chk("rst io_address", {ioa0, ioa3}, 32'd0);
        chk("rst io_wdata", {iowd0, iowd3}, 32'd0);
        chk("rst io_be", {28'd0, iobe0, iobe3}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Word write/read, then byte write at the odd address.
        mem_op(0, 1, 20'h01234, 1'b1, 16'hBEEF, "word wr");
        mem_op(0, 0, 20'h01234, 1'b1, 16'h0000, "word rd");
        chk("word rd value", {16'd0, rd0}, 32'h0000BEEF);
        mem_op(0, 1, 20'h01235, 1'b1, 16'h5A00, "odd byte wr");
        mem_op(0, 0, 20'h01234, 1'b1, 16'h0000, "merged rd");
        chk("merged rd value", {16'd0, rd0}, 32'h00005AEF);
        mem_op(0, 0, 20'h01234, 1'b0, 16'h0000, "lower rd");

        // No-lane write leaves RAM untouched; no-lane read returns zero.
        mem_op(0, 1, 20'h00200, 1'b1, 16'h1357, "nolane init");
        mem_op(0, 1, 20'h00201, 1'b0, 16'hFFFF, "nolane wr");
        mem_op(0, 0, 20'h00201, 1'b0, 16'h0000, "nolane rd");
        mem_op(0, 0, 20'h00200, 1'b1, 16'h0000, "nolane check");

        // Unknown status code is ignored.
        @(negedge clk);
        st0 = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("bad status", {29'd0, rdyb0, ior0, iow0}, 32'd4);
        end
        @(negedge clk);
        st0 = ST_IDLE;
        @(posedge clk); #1;

        // IO read with a late ack, plus the ack-in-strobe-cycle case.
        io_op(0, 20'h000A0, 1'b1, 16'h0000, 5, 16'h1234, "io rd a0");
        io_op(1, 20'h0C0DE, 1'b1, 16'hA55A, 1, 16'h0000, "io wr fast");
        io_op(0, 20'h00031, 1'b1, 16'h0000, 1, 16'hCAFE, "io rd odd");

        // Wait-state instance: preload, read at the address and at a mirror alias.
        mem_op(3, 1, 20'hFFFF0, 1'b1, 16'h00EA, "ws3 preload");
        mem_op(3, 0, 20'hFFFF0, 1'b1, 16'h0000, "ws3 rd");
        chk("ws3 rd value", {16'd0, rd3}, 32'h000000EA);
        mem_op(3, 0, 20'h1FFF0, 1'b1, 16'h0000, "ws3 mirror rd");

        // Reset while waiting aborts the read; the next read completes normally.
        mem_op(3, 1, 20'h00100, 1'b1, 16'h1111, "ws3 rst init");
        @(negedge clk);
        addr = 20'h00100; ube = 1'b1; st3 = ST_MRD;
        @(posedge clk); #1;
        chk("rst-abort wait readyb", {31'd0, rdyb3}, 32'd1);
        @(negedge clk);
        st3 = ST_IDLE; reset = 1'b1;
        @(posedge clk); #1;
        chk("rst-abort readyb", {31'd0, rdyb3}, 32'd1);
        chk("rst-abort rdata", {rd0, rd3}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("rst-abort idle readyb", {31'd0, rdyb3}, 32'd1);
        end
        mem_op(3, 0, 20'h00100, 1'b1, 16'h0000, "ws3 after rst");

        // Randomized traffic over a small pool of words with random mirror bits.
        for (int i = 0; i < 8; i++) begin
            pool[i] = {3'($urandom), 12'($urandom), 4'(i), 1'b0};
            mem_op(0, 1, pool[i], 1'b1, 16'($urandom), $sformatf("pool init %0d", i));
        end
        for (int i = 0; i < 40; i++) begin
            logic [19:0] a;
            int op;
            a = pool[$urandom_range(7, 0)];
            a[19:17] = 3'($urandom);
            a[0] = 1'($urandom);
            op = $urandom_range(3, 0);
            case (op)
                0: mem_op(0, 0, a, 1'($urandom), 16'h0, $sformatf("rnd mrd %0d", i));
                1: mem_op(0, 1, a, 1'($urandom), 16'($urandom), $sformatf("rnd mwr %0d", i));
                2: io_op(0, a, 1'($urandom), 16'h0, $urandom_range(6, 1), 16'($urandom),
                         $sformatf("rnd iord %0d", i));
                default: io_op(1, a, 1'($urandom), 16'($urandom), $urandom_range(6, 1), 16'h0,
                               $sformatf("rnd iowr %0d", i));
            endcase
        end
        for (int i = 0; i < 8; i++) begin
            mem_op(0, 0, pool[i], 1'b1, 16'h0, $sformatf("pool final %0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/v30mz_bus_responder.md
# v30mz_bus_responder

Memory/IO-side responder for the V30MZ external bus. It decodes the CPU's `bus_status`, `address_out` and `bus_upper_byte_enable`, and serves memory cycles from an internal word-wide RAM. IO cycles go to an external IO port over a request/acknowledge handshake. It returns read data and the active-low `readyb` completion strobe that the CPU's bus logic and prefetch queue wait on.

## Interface

Parameters:
- `MEM_ADDR_BITS`, default 16: RAM word-address width (2^16 words = 128 KiB). Memory is mirrored across the 1 MiB space; the word index is `bus_address[MEM_ADDR_BITS:1]`.
- `WAIT_STATES`, default 0: extra cycles inserted before `readyb` falls on memory cycles (0–15).

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `bus_address`  in  20  CPU `address_out`.
- `bus_status`  in  4  CPU status: 4'hf idle, 4'b1001 mem read, 4'b1010 mem write, 4'b0101 IO read, 4'b0110 IO write.
- `bus_upper_byte_enable`  in  1  high selects lane [15:8].
- `bus_wdata`  in  16  CPU `data_out`.
- `bus_rdata`  out  16  read data to CPU `data_in`.
- `readyb`  out  1  low for exactly one cycle when a cycle completes.
- `io_address`  out  16  `bus_address[15:0]` latched at capture.
- `io_byte_enable`  out  2  {upper, lower} lanes.
- `io_read`  out  1  one-cycle strobe.
- `io_write`  out  1  one-cycle strobe.
- `io_wdata`  out  16  latched `bus_wdata`.
- `io_rdata`  in  16  IO read data, valid with `io_ack`.
- `io_ack`  in  1  IO completion; any cycle from the strobe cycle onward.

## Operation

- Lane decode at capture: lower = !A0; upper = `bus_upper_byte_enable`.
  - Even address with UBE: word access.
  - Odd address with UBE: upper byte only.
  - Even address without UBE: lower byte only.
  - Odd address without UBE: no lanes. The cycle still completes, writes nothing, and reads return 16'h0000.
- Read data: enabled lanes carry RAM or IO bytes in place (no byte swapping); disabled lanes are driven 0.
- Writes: only enabled lanes of the RAM word or IO transfer are updated, from `bus_wdata` in place.
- FSM states:
  - IDLE: `readyb`=1. Sample `bus_status`. On a valid mem code, latch address, lanes and write data, issue the RAM access and go to WAIT, or to DONE if `WAIT_STATES`=0. On a valid IO code, latch, pulse `io_read`/`io_write`, and go to IO_WAIT. Any other code is ignored.
  - WAIT: down-counter loaded with `WAIT_STATES`; go to DONE at 1.
  - IO_WAIT: on `io_ack`, capture `io_rdata` and go to DONE. No timeout.
  - DONE: `readyb`=0 and `bus_rdata` valid this cycle; go to TURN.
  - TURN: `readyb`=1 and `bus_status` ignored for one cycle, which absorbs the CPU's registered status update; go to IDLE.
- RAM writes commit at the capture edge. RAM reads are registered with 1-cycle latency and held in an output register until the next capture.
- `io_ack` arriving in the strobe cycle is honoured; it means DONE follows next cycle.
- `io_ack` outside IO_WAIT is ignored.
- Status changing mid-cycle (after capture) is ignored; the latched request completes.

## Timing

- Reset values: `readyb`=1, `bus_rdata`=0, `io_read`=`io_write`=0, `io_address`=0, `io_byte_enable`=0, `io_wdata`=0; FSM in IDLE. RAM contents are not cleared.
- Reset mid-cycle: abort to IDLE the next edge with outputs at their reset values. A pending RAM write already committed stays.
- Memory cycle: capture edge at cycle 0; `readyb` low in cycle 1+`WAIT_STATES`; back in IDLE at 3+`WAIT_STATES`.
- Back-to-back memory cycles at `WAIT_STATES`=0: one completion every 3 cycles.
- IO cycle: `readyb` low one cycle after the cycle in which `io_ack` is seen.

## Structure

- Shared package `v30mz_bus_pkg`:
  - `bus_status_t` codes (BUS_STATUS_IDLE/MEM_READ/MEM_WRITE/IO_READ/IO_WRITE);
  - the responder state enum;
  - a lane-decode function.
- The CPU top also imports the package for its status encodings.
- One sub-module, `bus_ram`: 2^`MEM_ADDR_BITS` x 16, two byte-write enables, registered read. It must infer block RAM.

## Test plan

- Write word 16'hBEEF to 20'h01234 with UBE=1, then read it back -> `readyb` low in cycle 1 after each capture; read returns 16'hBEEF.
- Write byte 8'h5A at odd 20'h01235 (UBE=1, data 16'h5A00), then word-read 20'h01234 -> 16'h5AEF; lower lane preserved.
- `WAIT_STATES`=3, read 20'hFFFF0 after preloading word 16'h00EA -> `readyb` low exactly at cycle 4, data 16'h00EA, mirrored index correct.
- IO read of port 16'h00A0 with `io_ack` delayed 5 cycles, `io_rdata`=16'h1234 -> single `io_read` pulse, `io_address`=16'h00A0, `readyb` low one cycle after the ack, data 16'h1234.
- Assert `reset` in WAIT during a read -> `readyb` stays 1, FSM in IDLE; a subsequent read completes normally.
- Odd address with UBE=0 write 16'hFFFF, then read -> RAM unchanged; the no-lane read returns 0 and still completes in 1 cycle; status 4'b0011 is ignored with `readyb` staying high.
